// File: rtl/uart_pkg.sv
// Shared UART definitions: parity modes, TX state encoding, frame sizing.
// Used by uart_tx_cfg and the planned uart_rx_cfg.
package uart_pkg;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } tx_state_e;

    function automatic int frame_bits(
        input int data_bits,
        input int parity,
        input int stop_bits
    );
        return 1 + data_bits + ((parity != PAR_NONE) ? 1 : 0) + stop_bits;
    endfunction

endpackage

// File: rtl/uart_tx_cfg_if.sv
// Valid/ready word handshake between a byte source and the UART TX.
interface uart_tx_cfg_if #(
    parameter int DATA_BITS = 8
);

    logic                 tx_valid;
    logic                 tx_ready;
    logic [DATA_BITS-1:0] tx_data;

    modport master (
        output tx_valid,
        output tx_data,
        input  tx_ready
    );

    modport slave (
        input  tx_valid,
        input  tx_data,
        output tx_ready
    );

endinterface

// File: rtl/uart_baud_cnt.sv
// Bit-period counter: runs 0..CLK_DIV-1 while enabled, held at 0 otherwise.
module uart_baud_cnt #(
    parameter int CLK_DIV = 434,
    parameter int CNT_W   = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic tick
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst_n || !en) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign tick = en && (cnt == LAST);

endmodule

// File: rtl/uart_tx_cfg.sv
// Parametrised UART transmitter: one accepted word yields exactly one frame.
module uart_tx_cfg
    import uart_pkg::*;
#(
    parameter int CLK_DIV   = 434,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1,
    parameter int CNT_W     = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    uart_tx_cfg_if.slave  bus,
    output logic          tx_pin,
    output logic          tx_busy,
    output logic          tx_done
);

    localparam int IW      = $clog2(DATA_BITS);
    localparam bit HAS_PAR = (PARITY != PAR_NONE);

    if (CLK_DIV < 2 || CLK_DIV > 65535 ||
        DATA_BITS < 5 || DATA_BITS > 9 ||
        PARITY < 0 || PARITY > 2 ||
        STOP_BITS < 1 || STOP_BITS > 2 ||
        (64'(1) << CNT_W) <= 64'(CLK_DIV)) begin : g_bad_param
        $error("uart_tx_cfg: illegal parameter value");
    end

    tx_state_e            state_q;
    tx_state_e            state_d;
    logic [DATA_BITS-1:0] shreg;
    logic [IW-1:0]        bit_idx;
    logic                 stop_idx;
    logic                 par_bit;
    logic                 tick;
    logic                 accept;
    logic                 last_bit;
    logic                 last_stop;

    assign accept    = bus.tx_valid && (state_q == ST_IDLE);
    assign last_bit  = (bit_idx == IW'(DATA_BITS - 1));
    assign last_stop = (STOP_BITS == 1) || stop_idx;

    assign bus.tx_ready = (state_q == ST_IDLE);
    assign tx_busy      = (state_q != ST_IDLE);

    uart_baud_cnt #(
        .CLK_DIV (CLK_DIV),
        .CNT_W   (CNT_W)
    ) u_baud (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (tx_busy),
        .tick  (tick)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        tx_pin  = 1'b1;
        tx_done = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) state_d = ST_START;
            end
            ST_START: begin
                tx_pin = 1'b0;
                if (tick) state_d = ST_DATA;
            end
            ST_DATA: begin
                tx_pin = shreg[0];
                if (tick && last_bit) begin
                    state_d = HAS_PAR ? ST_PARITY : ST_STOP;
                end
            end
            ST_PARITY: begin
                tx_pin = par_bit;
                if (tick) state_d = ST_STOP;
            end
            ST_STOP: begin
                if (tick && last_stop) begin
                    tx_done = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Parity is fixed at accept time so later tx_data changes cannot leak in.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shreg    <= '0;
            bit_idx  <= '0;
            stop_idx <= 1'b0;
            par_bit  <= 1'b0;
        end else begin
            if (accept) begin
                shreg    <= bus.tx_data;
                bit_idx  <= '0;
                stop_idx <= 1'b0;
                par_bit  <= (PARITY == PAR_ODD) ? ~^bus.tx_data
                                                :  ^bus.tx_data;
            end
            if (tick && state_q == ST_DATA) begin
                shreg   <= shreg >> 1;
                bit_idx <= bit_idx + IW'(1);
            end
            if (tick && state_q == ST_STOP) begin
                stop_idx <= ~stop_idx;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Directed bench for uart_tx_cfg: four configurations driven from one sequence.
module tb_uart_tx_cfg;

    logic       clk;
    logic       rst_n;
    logic [3:0] vld;
    logic [7:0] dat [4];
    logic [3:0] pin;
    logic [3:0] busy;
    logic [3:0] done;
    logic [3:0] rdy;

    int total = 0;
    int bad   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    uart_tx_cfg_if #(.DATA_BITS(8)) b0 ();
    uart_tx_cfg_if #(.DATA_BITS(8)) b1 ();
    uart_tx_cfg_if #(.DATA_BITS(8)) b2 ();
    uart_tx_cfg_if #(.DATA_BITS(7)) b3 ();

    assign b0.tx_valid = vld[0];
    assign b1.tx_valid = vld[1];
    assign b2.tx_valid = vld[2];
    assign b3.tx_valid = vld[3];
    assign b0.tx_data  = dat[0];
    assign b1.tx_data  = dat[1];
    assign b2.tx_data  = dat[2];
    assign b3.tx_data  = dat[3][6:0];
    assign rdy = {b3.tx_ready, b2.tx_ready, b1.tx_ready, b0.tx_ready};

    uart_tx_cfg #(.CLK_DIV(4), .DATA_BITS(8), .PARITY(0),
                  .STOP_BITS(1), .CNT_W(16)) u0 (
        .clk(clk), .rst_n(rst_n), .bus(b0),
        .tx_pin(pin[0]), .tx_busy(busy[0]), .tx_done(done[0]));

    uart_tx_cfg #(.CLK_DIV(4), .DATA_BITS(8), .PARITY(2),
                  .STOP_BITS(1), .CNT_W(16)) u1 (
        .clk(clk), .rst_n(rst_n), .bus(b1),
        .tx_pin(pin[1]), .tx_busy(busy[1]), .tx_done(done[1]));

    uart_tx_cfg #(.CLK_DIV(4), .DATA_BITS(8), .PARITY(1),
                  .STOP_BITS(1), .CNT_W(16)) u2 (
        .clk(clk), .rst_n(rst_n), .bus(b2),
        .tx_pin(pin[2]), .tx_busy(busy[2]), .tx_done(done[2]));

    uart_tx_cfg #(.CLK_DIV(3), .DATA_BITS(7), .PARITY(0),
                  .STOP_BITS(2), .CNT_W(16)) u3 (
        .clk(clk), .rst_n(rst_n), .bus(b3),
        .tx_pin(pin[3]), .tx_busy(busy[3]), .tx_done(done[3]));

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge with vld/dat already set; the next posedge accepts.
    task automatic frame(input int k, input int div, input int nb,
                         input logic [15:0] bits, input logic hold,
                         input logic [7:0] nxt, input int pulse_at,
                         input string tag);
        int   last;
        int   done_cnt;
        int   done_cyc;
        int   rdy_low;
        int   busy_hi;
        logic obs;
        last     = nb * div;
        done_cnt = 0;
        done_cyc = 0;
        rdy_low  = 0;
        busy_hi  = 0;
        for (int j = 0; j < nb; j++) begin
            obs = bits[j];
            for (int c = j * div + 1; c <= (j + 1) * div; c++) begin
                @(negedge clk);
                if (c == 1) begin
                    dat[k] = nxt;
                    if (!hold) vld[k] = 1'b0;
                end
                if (pulse_at != 0 && c == pulse_at) vld[k] = 1'b1;
                if (pulse_at != 0 && c == pulse_at + 1) vld[k] = 1'b0;
                if (pin[k] !== bits[j]) obs = pin[k];
                if (done[k] === 1'b1) begin
                    done_cnt++;
                    done_cyc = c;
                end
                if (rdy[k] === 1'b0) rdy_low++;
                if (busy[k] === 1'b1) busy_hi++;
            end
            chk($sformatf("%s_bit%0d", tag, j), 32'(obs), 32'(bits[j]));
        end
        chk({tag, "_done_cnt"}, done_cnt, 1);
        chk({tag, "_done_cyc"}, done_cyc, last);
        chk({tag, "_rdy_low"}, rdy_low, last);
        chk({tag, "_busy_hi"}, busy_hi, last);
        @(negedge clk);
        chk({tag, "_idle"}, {pin[k], rdy[k], busy[k], done[k]}, 4'b1100);
    endtask

    initial begin
        int dcnt;
        int lcnt;
        rst_n = 1'b0;
        vld   = '0;
        for (int i = 0; i < 4; i++) dat[i] = 8'h00;

        repeat (2) @(negedge clk);
        chk("rst_pin", pin, 4'hF);
        chk("rst_rdy", rdy, 4'hF);
        chk("rst_busy", busy, 4'h0);
        chk("rst_done", done, 4'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // 8N1 div4 0xA5
        vld[0] = 1'b1; dat[0] = 8'hA5;
        frame(0, 4, 10, 16'h034A, 1'b0, 8'hA5, 0, "n1_a5");

        // 8E1 / 8O1 div4 0xA5
        vld[1] = 1'b1; dat[1] = 8'hA5;
        frame(1, 4, 11, 16'h054A, 1'b0, 8'hA5, 0, "e1_a5");
        vld[2] = 1'b1; dat[2] = 8'hA5;
        frame(2, 4, 11, 16'h074A, 1'b0, 8'hA5, 0, "o1_a5");

        // 7N2 div3 0x3F
        vld[3] = 1'b1; dat[3] = 8'h3F;
        frame(3, 3, 10, 16'h037E, 1'b0, 8'h3F, 0, "n2_3f");

        // back-to-back 0x55 then 0x0F with valid held across the gap
        vld[0] = 1'b1; dat[0] = 8'h55;
        frame(0, 4, 10, 16'h02AA, 1'b1, 8'h0F, 0, "b2b_55");
        frame(0, 4, 10, 16'h021E, 1'b0, 8'h0F, 0, "b2b_0f");

        // data changed mid-frame plus valid pulse while busy
        vld[0] = 1'b1; dat[0] = 8'hA5;
        frame(0, 4, 10, 16'h034A, 1'b0, 8'h3C, 10, "mid_a5");
        repeat (5) @(negedge clk);
        chk("mid_no_extra", {busy[0], pin[0]}, 2'b01);

        // reset during data bit 3 of 0x00
        vld[0] = 1'b1; dat[0] = 8'h00;
        @(negedge clk);
        vld[0] = 1'b0;
        chk("rst_mid_start", pin[0], 1'b0);
        repeat (17) @(negedge clk);
        chk("rst_mid_bit3", {pin[0], rdy[0], busy[0]}, 3'b001);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("rst_mid_after", {pin[0], rdy[0], busy[0]}, 3'b110);
        dcnt = 0;
        lcnt = 0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (done[0] === 1'b1) dcnt++;
            if (pin[0] !== 1'b1) lcnt++;
        end
        chk("rst_mid_no_done", dcnt, 0);
        chk("rst_mid_line_hi", lcnt, 0);

        vld[0] = 1'b1; dat[0] = 8'h81;
        frame(0, 4, 10, 16'h0302, 1'b0, 8'h81, 0, "post_81");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_tx_cfg.md
Name: uart_tx_cfg

Overview:
Parametrised UART transmitter; next generation of the fixed 8N1 serial TX.
- Configurable bit period, data width, parity mode and stop-bit count.
- Valid/ready handshake replaces the level-enable: one accepted word produces exactly one frame.
- Sits between the byte source (FIFO or command logic) and the FPGA TX pin.

Parameters:
CLK_DIV, 434, clock cycles per serial bit (50 MHz / 115200); legal range 2..65535
DATA_BITS, 8, payload bits per frame; legal range 5..9
PARITY, 0, parity mode: 0 none, 1 odd, 2 even
STOP_BITS, 1, stop bits per frame; 1 or 2
CNT_W, 16, bit-period counter width; must satisfy 2^CNT_W > CLK_DIV

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous active-low reset
tx_valid  in  1  source has a word to send
tx_ready  out  1  block can accept a word; high only in IDLE
tx_data  in  DATA_BITS  payload, sampled on accept cycle only
tx_pin  out  1  serial line output, idle high
tx_busy  out  1  frame in progress
tx_done  out  1  one-cycle pulse at end of frame

Behaviour:
- Reset: sampled on rising clk when rst_n=0. Forces state IDLE, tx_pin=1, tx_busy=0, tx_done=0, tx_ready=1, counters 0. Reset mid-frame aborts the frame; line returns high on the next edge, with no partial stop bit.
- Accept: tx_valid && tx_ready at a rising edge. tx_data is latched into a shift register; the parity bit is computed from the latched word. Later changes on tx_data are ignored.
- State machine: IDLE -> START -> DATA -> PARITY (skipped if PARITY=0) -> STOP -> IDLE.
- Latency: tx_pin goes low on the edge following the accept edge.
- Bit timing: every bit, including each stop bit, is held exactly CLK_DIV cycles. The bit-period counter runs 0..CLK_DIV-1 and wraps; a tick on count CLK_DIV-1 advances the state or bit index.
- DATA order: LSB first, DATA_BITS bits. The bit index runs 0..DATA_BITS-1; leave DATA after index DATA_BITS-1 ticks.
- PARITY bit value: odd = ~^data, even = ^data.
- STOP: line high for STOP_BITS*CLK_DIV cycles.
- tx_done: asserted on the last cycle of the final stop bit.
- IDLE: entered on the next edge with tx_pin=1.
- tx_busy: high in every state except IDLE.
- tx_ready: combinational (state==IDLE).
- Frame length: N = 1+DATA_BITS+(PARITY!=0)+STOP_BITS bits. The cycle count from accept edge to tx_done pulse end is N*CLK_DIV.
- Back-to-back: with tx_valid held high, the next accept occurs in the single IDLE cycle. Frame-to-frame period is N*CLK_DIV+1 cycles and the line stays high in the gap.
- tx_valid while busy: ignored. The source must hold tx_valid until the handshake completes; there is no queueing.
- Illegal parameter values: elaboration-time error via generate-if assertion. There is no runtime behaviour for illegal values.

Decomposition:
- Shared package uart_pkg:
  - parity constants PAR_NONE/PAR_ODD/PAR_EVEN
  - state enum (IDLE, START, DATA, PARITY, STOP)
  - helper function for frame bit count, reused by the future uart_rx_cfg
- Sub-module uart_baud_cnt (params CLK_DIV, CNT_W; ports clk, rst_n, en, tick):
  - clears when en=0
  - tick is high on count CLK_DIV-1

Test Plan:
- CLK_DIV=4, 8N1, send 0xA5 -> tx_pin 0,1,0,1,0,0,1,0,1,1, each held 4 cycles; tx_done pulses at cycle 40 after accept; tx_ready low cycles 1..40.
- CLK_DIV=4, 8E1 / 8O1, send 0xA5 -> parity bit 0 (even) / 1 (odd) in bit slot 9; frame 44 cycles.
- CLK_DIV=3, DATA_BITS=7, STOP_BITS=2, PARITY=0, send 0x3F -> 0,1,1,1,1,1,1,0,1,1, each held 3 cycles; 30 cycles total.
- CLK_DIV=4, 8N1, tx_valid held with 0x55 then 0x0F -> second start bit begins exactly 41 cycles after first; one high idle cycle between frames; both frames bit-exact.
- tx_data changed mid-frame and tx_valid pulsed while busy -> frame unchanged, no extra frame, tx_ready stays 0.
- rst_n low for 1 cycle during data bit 3 of 0x00 -> tx_pin=1 and tx_ready=1 the next edge, tx_done never pulses; a new 0x81 accept afterward transmits correctly.
